sync_fifo_ctrl: RTL
===================

# sync_fifo_ctrl

Parametrised single-clock FIFO controller: the generalised successor of our fixed 8-entry FIFO buffer, integrating storage, read/write pointers, occupancy counting and status flags in one block. Sits between a producer and a consumer in the same clock domain, such as a register-file or UART-path data buffer. Adds configurable depth and width, programmable almost-full/almost-empty thresholds, flush, a registered read port with valid, and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 8: width of each entry
- ADDR_WIDTH, 3: depth is DEPTH = 2**ADDR_WIDTH (default 8); legal range 2..10
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1

Ports:
- w_clk  in  1  single clock; all logic on its rising edge
- w_rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of pointers, count and error flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data holds a newly read entry
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- clr_err  in  1  clears overflow/underflow
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Reset values, when w_rst_n is low at an edge: pointers 0, count 0, rd_data 0, rd_valid 0, overflow 0, underflow 0; therefore empty 1, full 0, almost_empty 1, almost_full (AF_LEVEL==0 impossible) 0.
- Storage contents are not reset. No read can reach an unwritten entry.
- Pointers are ADDR_WIDTH+1 bits wide: the low bits index storage, and the MSB is a wrap bit. Pointers wrap naturally from DEPTH-1 to 0 in the low bits. count is a register, not derived from the pointers.
- Write accept: wr_en && !full. Stores wr_data at wr_ptr and increments wr_ptr.
- Read accept: rd_en && !empty. Loads rd_data from mem[rd_ptr], increments rd_ptr and pulses rd_valid for 1 cycle.
- No read accept: rd_data holds its previous value and rd_valid is 0.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Full with both requests: the read is accepted and the write is rejected. There is no pass-through.
- Empty with both requests: the write is accepted and the read is rejected. There is no bypass; data is readable the following cycle.
- Rejected write (wr_en && full) sets overflow. Rejected read (rd_en && empty) sets underflow.
- clr_err clears both error flags. If an error and clr_err occur in the same cycle, set wins.
- flush: pointers, count and error flags go to 0 and rd_valid goes to 0. wr_en and rd_en in that cycle are ignored and set no error flags. rd_data holds its value.
- Priority: w_rst_n > flush > normal operation.
- Status flags are combinational decodes of the registered count only, so they are glitch-free relative to w_clk.

## Timing
- Write latency: wr_en accepted at edge N makes empty deassert and count increment after edge N. The entry is readable with rd_en at edge N+1.
- Read latency: rd_en accepted at edge N makes rd_data and rd_valid valid after edge N for exactly 1 cycle. Back-to-back reads give a continuous rd_valid.
- Flags and count update at the same edge as the accepting operation. There is no extra pipeline stage.
- A reset or flush asserted mid-burst takes effect at that edge. The next cycle is an empty FIFO with rd_valid 0.
- Throughput: 1 write and 1 read per cycle sustained.

## Test plan
- Reset then fill (DEPTH 8, defaults): write 0x01..0x08 on consecutive cycles -> count steps 1..8. almost_full rises when count reaches 6. full rises after the 8th write. A 9th write (0xFF) sets overflow, and count stays 8.
- Drain: read 8 times back-to-back -> rd_data 0x01..0x08 on consecutive cycles with rd_valid held high. empty rises after the 8th read. A 9th read sets underflow, and rd_data stays 0x08.
- Wrap-around: write 5, read 5, write 8 (0xA0..0xA7), read 8 -> data order preserved across the pointer wrap, and full and empty assert at the correct counts.
- Simultaneous read and write:
  - At count 4: count stays 4 and data order is preserved.
  - At full: the read is accepted, the write is dropped, overflow is set and count becomes 7.
  - At empty: the write is accepted, the read is rejected, underflow is set and count becomes 1.
- Flush and error clear: at count 5 with overflow set, assert flush together with wr_en -> count 0, empty 1, overflow 0 next cycle, and the write is not stored. In a separate case, clr_err plus a new rejected read -> underflow remains 1.
- Reset mid-operation: w_rst_n low during a read burst -> after that edge count is 0, rd_valid 0, rd_data 0 and the flags are at their reset values. The first write after reset reads back correctly.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with storage, pointers, occupancy count,
// programmable almost-full/almost-empty, flush and sticky error flags.
//
// Ports:
//   w_clk, w_rst_n   clock, synchronous active-low reset
//   flush            synchronous clear of pointers, count, error flags
//   wr_en, wr_data   write request and data
//   rd_en            read request
//   rd_data          registered read data
//   rd_valid         one-cycle pulse, rd_data holds a newly read entry
//   full, empty      count == DEPTH / count == 0
//   almost_full      count >= AF_LEVEL
//   almost_empty     count <= AE_LEVEL
//   count            occupancy 0..DEPTH
//   clr_err          clears overflow/underflow (a new error wins)
//   overflow         sticky: a write was rejected
//   underflow        sticky: a read was rejected
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ZERO    = '0;
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // MSB of each pointer is the wrap bit; low bits index storage.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic wr_acc;
    logic rd_acc;
    logic ovf_set;
    logic unf_set;

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign wr_idx = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr[ADDR_WIDTH-1:0];

    // Flags come only from the registered count.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == ZERO);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // Full blocks the write and empty blocks the read, so with both
    // requests the FIFO never passes data through or bypasses storage.
    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign ovf_set = wr_en && full;
    assign unf_set = rd_en && empty;

    always_comb begin
        count_nxt = count_q;
        unique case (1'b1)
            wr_acc && !rd_acc: count_nxt = count_q + ONE;
            rd_acc && !wr_acc: count_nxt = count_q - ONE;
            default: ;
        endcase
    end

    // Storage is not reset; the count guarantees unwritten entries are
    // never read.
    always_ff @(posedge w_clk) begin
        if (w_rst_n && !flush && wr_acc) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            // rd_data deliberately keeps its last value.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            count_q    <= count_nxt;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + ONE;
                rd_data_q <= mem[rd_idx];
            end
            // A new error in the same cycle as clr_err wins.
            overflow_q  <= ovf_set | (overflow_q & ~clr_err);
            underflow_q <= unf_set | (underflow_q & ~clr_err);
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
